// File: rtl/pc_unit_irq_vec.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_irq_vec
// Description : Fetch-stage program counter with vectored, maskable,
//               multi-line interrupts, EPC save and mret return.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit_irq_vec #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              STEP      = 4,
    parameter int              NUM_IRQ   = 4,
    localparam int             CW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump,
    input  logic               branch,
    input  logic               zero_flag,
    input  logic [XLEN-1:0]    pc_target,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               mret,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    epc,
    output logic               in_handler,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [CW-1:0]      irq_cause
);

    localparam logic [XLEN-1:0] c_step = XLEN'(STEP);

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_HANDLER = 1'b1
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_epc;
    logic [NUM_IRQ-1:0]  r_ack;
    logic [CW-1:0]       r_cause;

    logic [NUM_IRQ-1:0]  w_pend;
    logic                w_any;
    logic [CW-1:0]       w_k;
    logic [XLEN-1:0]     w_seq_next;
    logic [XLEN-1:0]     w_vec;

    assign w_pend = irq & irq_en;
    assign w_any  = |w_pend;

    // Scan downward so the lowest set index (highest priority) wins.
    always_comb begin
        w_k = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_k = CW'(i);
            end
        end
    end

    assign w_seq_next = jump                 ? pc_target :
                        (branch & zero_flag) ? pc_target :
                                               r_pc + c_step;

    assign w_vec = TRAP_VEC + c_step * XLEN'(w_k);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= RESET_VEC;
            r_epc   <= '0;
            r_ack   <= '0;
            r_cause <= '0;
        end else begin
            r_ack <= '0;
            if (!stall) begin
                if (r_state == S_RUN && w_any) begin
                    // Save the redirected path so an in-flight jump/branch survives the trap.
                    r_epc   <= w_seq_next;
                    r_pc    <= w_vec;
                    r_cause <= w_k;
                    r_ack   <= NUM_IRQ'(1) << w_k;
                    r_state <= S_HANDLER;
                end else if (r_state == S_HANDLER && mret) begin
                    r_pc    <= r_epc;
                    r_state <= S_RUN;
                end else begin
                    r_pc    <= w_seq_next;
                end
            end
        end
    end

    assign pc         = r_pc;
    assign epc        = r_epc;
    assign in_handler = (r_state == S_HANDLER);
    assign irq_ack    = r_ack;
    assign irq_cause  = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit_irq_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit_irq_vec
// Description : Scoreboard bench for pc_unit_irq_vec (4 lines, 32-bit PC).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit_irq_vec;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, jump, branch, zero_flag, mret;
    logic [31:0] pc_target;
    logic [3:0]  irq, irq_en;
    logic [31:0] pc, epc;
    logic        in_handler;
    logic [3:0]  irq_ack;
    logic [1:0]  irq_cause;

    pc_unit_irq_vec #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .TRAP_VEC  (32'h100),
        .STEP      (4),
        .NUM_IRQ   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .jump       (jump),
        .branch     (branch),
        .zero_flag  (zero_flag),
        .pc_target  (pc_target),
        .irq        (irq),
        .irq_en     (irq_en),
        .mret       (mret),
        .pc         (pc),
        .epc        (epc),
        .in_handler (in_handler),
        .irq_ack    (irq_ack),
        .irq_cause  (irq_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        h;
        logic [3:0]  ack;
        logic [1:0]  cause;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;

    // Reference state
    logic [31:0] m_pc, m_epc;
    logic        m_h;
    logic [3:0]  m_ack;
    logic [1:0]  m_cause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_h = 1'b0; m_ack = 4'h0; m_cause = 2'd0;
    endtask

    task automatic model_step();
        logic [31:0] seq;
        logic [3:0]  pend;
        exp_t        e;
        int          k;
        seq  = jump ? pc_target : ((branch && zero_flag) ? pc_target : m_pc + 32'd4);
        pend = irq & irq_en;
        k = -1;
        for (int i = 3; i >= 0; i--) if (pend[i]) k = i;
        m_ack = 4'h0;
        if (!stall) begin
            if (!m_h && k >= 0) begin
                m_epc   = seq;
                m_pc    = 32'h100 + 32'(4 * k);
                m_cause = 2'(k);
                m_ack   = 4'(1 << k);
                m_h     = 1'b1;
            end else if (m_h && mret) begin
                m_pc = m_epc;
                m_h  = 1'b0;
            end else begin
                m_pc = seq;
            end
        end
        e.pc = m_pc; e.epc = m_epc; e.h = m_h; e.ack = m_ack; e.cause = m_cause;
        q.push_back(e);
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_pc"},    pc,                e.pc);
        chk({tag, "_epc"},   epc,               e.epc);
        chk({tag, "_inh"},   32'(in_handler),   32'(e.h));
        chk({tag, "_ack"},   32'(irq_ack),      32'(e.ack));
        chk({tag, "_cause"}, 32'(irq_cause),    32'(e.cause));
    endtask

    // Inputs are driven 1 time unit after posedge; outputs sampled 1 after the next.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle_inputs();
        stall = 0; jump = 0; branch = 0; zero_flag = 0; mret = 0;
        pc_target = 32'h0; irq = 4'h0; irq_en = 4'h0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_pc",    pc,                32'h0);
        chk("rst_epc",   epc,               32'h0);
        chk("rst_inh",   32'(in_handler),   32'h0);
        chk("rst_ack",   32'(irq_ack),      32'h0);
        chk("rst_cause", 32'(irq_cause),    32'h0);

        // 1: free-running increment
        for (int i = 1; i <= 4; i++) begin
            step("t1");
            chk("t1_pc_lit", pc, 32'(4 * i));
        end
        repeat (4) step("t1b");
        chk("t1_pc_0x20", pc, 32'h20);

        // 2: two lines pending, line 1 wins
        irq = 4'b0110; irq_en = 4'hF;
        step("t2");
        chk("t2_pc",    pc,             32'h104);
        chk("t2_epc",   epc,            32'h24);
        chk("t2_cause", 32'(irq_cause), 32'd1);
        chk("t2_ack",   32'(irq_ack),   32'b0010);
        step("t2_hold");
        chk("t2_noreentry_pc",  pc,            32'h108);
        chk("t2_ack_pulse_end", 32'(irq_ack),  32'h0);
        irq = 4'h0; mret = 1;
        step("t2_mret");
        chk("t2_ret_pc", pc, 32'h24);
        mret = 0;

        // 3: trap during a jump keeps the jump target in EPC; mret beats jump
        jump = 1; pc_target = 32'h40;
        step("t3_j40");
        pc_target = 32'h80; irq = 4'b0001;
        step("t3_trap");
        chk("t3_pc",  pc,  32'h100);
        chk("t3_epc", epc, 32'h80);
        jump = 0; irq = 4'h0;
        step("t3_h");
        mret = 1; jump = 1; pc_target = 32'h200;
        step("t3_mret");
        chk("t3_ret_pc", pc, 32'h80);
        mret = 0; jump = 0;

        // branch not taken / taken
        branch = 1; zero_flag = 0; pc_target = 32'h300;
        step("br_nt");
        chk("br_nt_pc", pc, 32'h84);
        zero_flag = 1;
        step("br_t");
        chk("br_t_pc", pc, 32'h300);
        branch = 0; zero_flag = 0;

        // 4: stall holds everything, then trap on line 2
        irq = 4'b0100; irq_en = 4'hF; stall = 1;
        repeat (3) step("t4_stall");
        chk("t4_stall_pc",  pc,            32'h300);
        chk("t4_stall_ack", 32'(irq_ack),  32'h0);
        stall = 0;
        step("t4_trap");
        chk("t4_pc",  pc,  32'h108);
        chk("t4_epc", epc, 32'h304);
        mret = 1; stall = 1;
        step("t4_mret_stalled");
        chk("t4_mret_stalled_pc", pc, 32'h108);
        stall = 0;
        step("t4_mret");
        chk("t4_ret_pc", pc, 32'h304);
        mret = 0;
        step("t4_retrap");
        chk("t4_retrap_pc",  pc,  32'h108);
        chk("t4_retrap_epc", epc, 32'h308);
        irq = 4'h0; mret = 1;
        step("t4_ret2");
        mret = 0;

        // 5: wrap, masked lines, mret ignored in RUN
        jump = 1; pc_target = 32'hFFFF_FFFC;
        step("t5_jtop");
        jump = 0;
        step("t5_wrap");
        chk("t5_wrap_pc", pc, 32'h0);
        irq = 4'hF; irq_en = 4'h0;
        repeat (2) step("t5_masked");
        chk("t5_masked_inh", 32'(in_handler), 32'h0);
        mret = 1;
        step("t5_mret_run");
        chk("t5_mret_run_pc", pc, 32'hC);
        mret = 0; irq = 4'h0;

        // 6: asynchronous reset while in handler
        irq = 4'b0001; irq_en = 4'b0001;
        step("t6_trap");
        irq = 4'h0;
        step("t6_h");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_pc",  pc,               32'h0);
        chk("t6_epc", epc,              32'h0);
        chk("t6_inh", 32'(in_handler),  32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("t6_after");
        chk("t6_after_pc", pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
